// File: rtl/pipelined_prefix_adder.sv
// ---------------------------------------------------------------------------
// pipelined_prefix_adder
//   WIDTH = 2**LEVELS bit add/subtract unit. The operand is cut into STAGES
//   equal slices; pipeline stage k resolves slice k with a parallel-prefix
//   (Kogge-Stone) adder. Stage k takes its carry from the registered carry of
//   stage k-1. Operands not yet consumed and the partially built sum travel
//   forward with their beat. A single global stall freezes every rank,
//   bubbles included, while the result is held.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat present
//   in_ready   unit accepts a beat this cycle
//   x, y       operands A and B
//   carry_in   carry in (add) / borrow in (subtract)
//   sub        0 = add, 1 = subtract
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   z          sum / difference
//   carry_out  add: carry out, subtract: NOT borrow
//   overflow   two's-complement signed overflow
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pipelined_prefix_adder_slice
//   Combinational SLICE-bit Kogge-Stone adder with carry in.
//   a, b  slice operands      ci  carry into bit 0
//   s     slice sum           co  carry out of the top bit
//   cm    carry into the top bit (feeds the signed-overflow term)
// ---------------------------------------------------------------------------
module pipelined_prefix_adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             cm
);
  localparam int LV = $clog2(SLICE);

  logic [SLICE-1:0] g, p, gn, pn;
  logic [SLICE:0]   c;

  // After the prefix tree, g[i]/p[i] are the group generate/propagate of
  // bits [i:0]; the carry into bit i+1 then only needs the external ci.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gn = g;
    pn = p;
    for (int l = 0; l < LV; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < SLICE; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
        pn[i] = p[i] & p[i - (1 << l)];
      end
      g = gn;
      p = pn;
    end
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      c[i + 1] = g[i] | (p[i] & ci);
    end
  end

  assign s  = (a ^ b) ^ c[SLICE-1:0];
  assign co = c[SLICE];
  assign cm = c[SLICE-1];
endmodule

module pipelined_prefix_adder #(
  parameter  int LEVELS = 3,
  parameter  int STAGES = 2,
  localparam int WIDTH  = 2 ** LEVELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry_out,
  output logic             overflow
);
  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_prefix_adder: STAGES=%0d must divide WIDTH=%0d", STAGES, WIDTH);
  end

  localparam int SLICE = WIDTH / STAGES;

  // One pipeline rank. ye/c are already the effective (possibly inverted)
  // operand and carry, so downstream stages never need to know about sub.
  typedef struct packed {
    logic [WIDTH-1:0] xe;
    logic [WIDTH-1:0] ye;
    logic [WIDTH-1:0] z;
    logic             c;
    logic             ov;
  } stage_t;

  stage_t             head;
  stage_t             stg_d [STAGES];
  stage_t             stg_q [STAGES];
  logic [STAGES-1:0]  vld_q;
  logic [STAGES:0]    vld_pipe;
  logic               stall;

  // vld_pipe[0] is the incoming beat, vld_pipe[k+1] the valid of rank k.
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Subtract is x + ~y + ~carry_in.
  always_comb begin
    head    = '0;
    head.xe = x;
    head.ye = y ^ {WIDTH{sub}};
    head.c  = carry_in ^ sub;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    logic [SLICE-1:0] s;
    logic             co;
    logic             cm;

    if (k == 0) begin : g_first
      assign src = head;
    end else begin : g_next
      assign src = stg_q[k-1];
    end

    pipelined_prefix_adder_slice #(.SLICE(SLICE)) u_slice (
      .a  (src.xe[k*SLICE +: SLICE]),
      .b  (src.ye[k*SLICE +: SLICE]),
      .ci (src.c),
      .s  (s),
      .co (co),
      .cm (cm)
    );

    // ov is rewritten by every stage; only the last slice's value, which
    // contains the MSB, survives to the output.
    always_comb begin
      nxt                     = src;
      nxt.z[k*SLICE +: SLICE] = s;
      nxt.c                   = co;
      nxt.ov                  = cm ^ co;
    end

    assign stg_d[k] = nxt;
  end

  // Global stall: every rank, bubbles included, holds while the head of the
  // pipe is blocked, which keeps the presented result stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else if (!stall) begin
      vld_q <= vld_pipe[STAGES-1:0];
      for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
    end
  end

  assign z         = stg_q[STAGES-1].z;
  assign carry_out = stg_q[STAGES-1].c;
  assign overflow  = stg_q[STAGES-1].ov;

  // All operand bits are consumed by the time a beat reaches the last rank.
  logic unused_tail;
  assign unused_tail = ^{stg_q[STAGES-1].xe, stg_q[STAGES-1].ye};
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
module tb_pipelined_prefix_adder;
  localparam int W    = 8;
  localparam int NCFG = 5;
  localparam int NBEAT = 1000;
  // Sweep configurations, element 0 first: (L,S) = (3,1) (3,2) (3,4) (3,8) (5,4)
  localparam logic [NCFG-1:0][3:0] CFG_L = {4'd5, 4'd3, 4'd3, 4'd3, 4'd3};
  localparam logic [NCFG-1:0][3:0] CFG_S = {4'd4, 4'd8, 4'd4, 4'd2, 4'd1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, carry_in, sub;
  logic         out_valid, out_ready, carry_out, overflow;
  logic [W-1:0] x, y, z;
  int           checks = 0;
  int           fails  = 0;
  bit           sw_done [NCFG];

  pipelined_prefix_adder #(.LEVELS(3), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .carry_out(carry_out), .overflow(overflow)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       ci;
    logic       sb;
    logic [7:0] z;
    logic       co;
    logic       ov;
    string      name;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: accepted at the end of the first cycle, result must
  // appear exactly two cycles later and not earlier.
  task automatic run_vec(input vec_t v);
    x = v.x; y = v.y; carry_in = v.ci; sub = v.sb;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({v.name, " in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0; x = ~v.x; y = ~v.y; carry_in = ~v.ci; sub = ~v.sb;
    @(negedge clk);
    chk({v.name, " early"}, out_valid, 0);
    tick();
    @(negedge clk);
    chk({v.name, " valid"}, out_valid, 1);
    chk({v.name, " z"}, z, v.z);
    chk({v.name, " carry"}, carry_out, v.co);
    chk({v.name, " ovf"}, overflow, v.ov);
    tick();
  endtask

  initial begin
    int acc, got, stalls, c;
    bit all;
    logic [7:0] exp_seq [4];
    logic [7:0] bpat;
    vec_t post;

    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01"};
    vecs[1]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07"};
    vecs[2]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01"};
    vecs[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01"};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, "add_cin"};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, "add_ff_ff_cin"};
    vecs[6]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_slice_carry"};
    vecs[7]  = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, "sub_slice_borrow"};
    vecs[8]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_borrow_in"};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "sub_zero"};
    vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, "sub_7f_ff"};
    vecs[11] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "add_80_80"};
    vecs[12] = '{8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "add_3c_5a"};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = 8'hAA; y = 8'h55; carry_in = 1'b1; sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset z", z, 0);
    chk("reset carry", carry_out, 0);
    chk("reset ovf", overflow, 0);
    chk("reset in_ready", in_ready, 1);
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: first result held for three cycles
    exp_seq = '{8'h02, 8'h04, 8'h06, 8'h08};
    acc = 0; got = 0; stalls = 0; c = 0;
    while (c < 40 && got < 4) begin
      in_valid = (acc < 4); x = 8'(acc + 1); y = 8'(acc + 1);
      carry_in = 1'b0; sub = 1'b0;
      out_ready = !(out_valid && stalls < 3);
      if (out_valid && !out_ready) stalls++;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("bp in_ready", in_ready, 0);
        chk("bp z held", z, 8'h02);
      end
      if (out_valid && out_ready) begin
        chk("bp result", z, exp_seq[got]);
        got++;
      end
      if (in_valid && in_ready) acc++;
      tick();
      c++;
    end
    chk("bp count", got, 4);
    chk("bp stalls", stalls, 3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp drained", out_valid, 0);
    tick();

    // Bubbles: in_valid 1,0,1,0 -> out_valid 1,0,1,0 two cycles later
    bpat = 8'b0001_0100;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k == 0 || k == 2);
      x = (k == 0) ? 8'h10 : (k == 2) ? 8'h20 : 8'hEE;
      y = (k == 0) ? 8'h01 : (k == 2) ? 8'h02 : 8'hEE;
      carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bubble out_valid", out_valid, bpat[k]);
      if (k == 2) chk("bubble z0", z, 8'h11);
      if (k == 4) chk("bubble z1", z, 8'h22);
      tick();
    end

    // Reset with two beats in flight
    in_valid = 1'b1; x = 8'h11; y = 8'h22; out_ready = 1'b1;
    tick();
    x = 8'h40; y = 8'h01;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("pre-reset valid", out_valid, 1);
    chk("pre-reset z", z, 8'h33);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst z", z, 0);
    chk("midrst carry", carry_out, 0);
    chk("midrst ovf", overflow, 0);
    chk("midrst in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("midrst no stale", out_valid, 0);
    end
    tick();
    post = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "post_reset"};
    run_vec(post);

    // Wait for the configuration sweep
    all = 1'b0;
    for (int k = 0; k < 20000 && !all; k++) begin
      all = 1'b1;
      for (int i = 0; i < NCFG; i++) if (!sw_done[i]) all = 1'b0;
      if (!all) @(posedge clk);
    end
    chk("sweep finished", all, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Configuration sweep: random beats, random out_ready, independent model.
  for (genvar gi = 0; gi < NCFG; gi++) begin : g_sweep
    localparam int L  = int'(CFG_L[gi]);
    localparam int S  = int'(CFG_S[gi]);
    localparam int SW = 2 ** L;

    logic          srst, sv, sir, sci, ssb, sov, sor, sco, sof;
    logic [SW-1:0] sx, sy, sz;
    logic [SW+1:0] q_res [$];
    int            q_cyc [$];
    bit            q_lat [$];

    pipelined_prefix_adder #(.LEVELS(L), .STAGES(S)) u_dut (
      .clk(clk), .rst(srst), .in_valid(sv), .in_ready(sir),
      .x(sx), .y(sy), .carry_in(sci), .sub(ssb),
      .out_valid(sov), .out_ready(sor),
      .z(sz), .carry_out(sco), .overflow(sof)
    );

    initial begin
      int sent, got, cyc, c0;
      bit lat;
      logic [SW:0]   wide;
      logic [SW-1:0] ez;
      logic          eco, eov;
      logic [SW+1:0] r;
      sent = 0; got = 0; cyc = 0;
      srst = 1'b1; sv = 1'b0; sor = 1'b1; sx = '0; sy = '0; sci = 1'b0; ssb = 1'b0;
      repeat (3) @(posedge clk);
      #1 srst = 1'b0;
      while (got < NBEAT && cyc < 8000) begin
        sv  = (sent < NBEAT) && ($urandom_range(0, 3) != 0);
        sx  = SW'($urandom);
        sy  = SW'($urandom);
        sci = 1'($urandom_range(0, 1));
        ssb = 1'($urandom_range(0, 1));
        sor = (cyc < 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (sov && sor) begin
          checks++;
          if (q_res.size() == 0) begin
            fails++;
            $display("FAIL sweep%0d extra beat: got z=%0h expected none", gi, sz);
          end else begin
            r   = q_res.pop_front();
            c0  = q_cyc.pop_front();
            lat = q_lat.pop_front();
            if ({sz, sco, sof} !== r) begin
              fails++;
              $display("FAIL sweep%0d result: got %0h/%0b/%0b expected %0h/%0b/%0b",
                       gi, sz, sco, sof, r[SW+1:2], r[1], r[0]);
            end
            if (lat) begin
              checks++;
              if (cyc - c0 != S) begin
                fails++;
                $display("FAIL sweep%0d latency: got %0d expected %0d", gi, cyc - c0, S);
              end
            end
          end
          got++;
        end
        if (sv && sir) begin
          if (!ssb) begin
            wide = {1'b0, sx} + {1'b0, sy} + {{SW{1'b0}}, sci};
            ez   = wide[SW-1:0];
            eco  = wide[SW];
            eov  = (sx[SW-1] == sy[SW-1]) && (ez[SW-1] != sx[SW-1]);
          end else begin
            ez  = sx - sy - {{(SW-1){1'b0}}, sci};
            eco = ({1'b0, sx} >= ({1'b0, sy} + {{SW{1'b0}}, sci}));
            eov = (sx[SW-1] != sy[SW-1]) && (ez[SW-1] != sx[SW-1]);
          end
          q_res.push_back({ez, eco, eov});
          q_cyc.push_back(cyc);
          q_lat.push_back(cyc + S < 200);
          sent++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      checks++;
      if (got != NBEAT) begin
        fails++;
        $display("FAIL sweep%0d beat count: got %0d expected %0d", gi, got, NBEAT);
      end
      sw_done[gi] = 1'b1;
    end
  end
endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined successor to the team's single-cycle 2**LEVELS-bit adder.
- Splits the operand into STAGES equal slices and resolves one slice per pipeline stage, carrying between stages through registers.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure.
- Sits between operand producers (register file / operand FIFO) and result consumers in the datapath.

Parameters:
- LEVELS, 3, operand width is WIDTH = 2**LEVELS bits.
- STAGES, 2, number of pipeline stages and register ranks. Legal range is 1..WIDTH, and STAGES must divide WIDTH; any other value is an elaboration error. SLICE = WIDTH/STAGES.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- carry_in  in  1  carry in for add; borrow in for subtract.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- z  out  WIDTH  sum or difference.
- carry_out  out  1  add: carry out; subtract: NOT borrow.
- overflow  out  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All stage valid bits clear, so out_valid=0 in the next cycle.
  - z, carry_out and overflow become 0.
  - All partial results and staged operands are discarded.
  - in_ready is high in the cycle after reset.
- Reset mid-operation discards in-flight beats; no stale beat may ever appear at the output.
- Arithmetic:
  - Add: {carry_out,z} = x + y + carry_in.
  - Subtract: the effective operand is ~y and the effective carry is ~carry_in, giving z = x - y - carry_in mod 2**WIDTH, with carry_out=1 iff no borrow.
  - overflow = carry into MSB XOR carry out of MSB, computed on the effective operands.
- Slicing:
  - Stage k (k = 0..STAGES-1) computes bits [k*SLICE +: SLICE] from the registered carry of stage k-1; stage 0 uses the effective carry.
  - Slices not yet computed travel forward in delay registers alongside their beat, together with sub and the partially built z.
- Latency:
  - A beat accepted at rising edge t (in_valid & in_ready) presents out_valid=1 with its result in the cycle after edge t+STAGES-1, i.e. a latency of STAGES cycles when there is no stall.
  - Throughput is one beat per cycle.
- Handshake:
  - in_ready = ~(out_valid & ~out_ready), a global stall.
  - When stalled, every stage register, including bubbles, holds its value. z, carry_out and overflow stay stable while out_valid=1 and out_ready=0.
  - When not stalled, all stages advance one position. A bubble enters stage 0 when in_valid=0.
  - A beat leaves on out_valid & out_ready. A new beat may be accepted in the same cycle as the last stage drains.
- Ordering: strictly in-order, with no loss and no duplication.
- Producer stall: in_valid may drop at any time; bubbles propagate and out_valid deasserts accordingly.
- Output when idle: z, carry_out and overflow outputs are don't-care while out_valid=0, except immediately after reset, when they are 0.
- STAGES=1: degenerates to a single registered adder with 1-cycle latency and the same handshake.

Test Plan (LEVELS=3, STAGES=2 unless noted):
- Add carry chain: x=8'hFF, y=8'h01, carry_in=0, sub=0 accepted at edge t -> out_valid high after edge t+1; z=8'h00, carry_out=1, overflow=0.
- Subtract with borrow: x=8'h05, y=8'h07, carry_in=0, sub=1 -> z=8'hFE, carry_out=0, overflow=0. Then x=8'h80, y=8'h01, sub=1 -> z=8'h7F, overflow=1. Then add x=8'h7F, y=8'h01 -> z=8'h80, overflow=1.
- Backpressure: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) with out_ready held low for 3 cycles after the first result -> in_ready low during the stall, z held at 8'h02, then results 02, 04, 06, 08 in order with none lost.
- Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 -> out_valid pattern 1,0,1,0 delayed by 2 cycles, with matching results.
- Reset mid-flight: rst asserted for 1 cycle while 2 beats are in flight -> out_valid=0 and z=0 in the next cycle, no stale result ever emerges, and the first beat accepted after reset returns correctly.
- Configuration sweep: STAGES in {1,2,4,8} with LEVELS=3, plus LEVELS=5 with STAGES=4, running 1000 random beats with random out_ready -> every beat matches the reference model and latency equals STAGES cycles when there is no stall.
